i2c_target: RTL and testbench



---
 rtl/i2c_target_if.sv | 23 ++
 rtl/i2c_target.sv | 175 +++++++++++++++++
 tb/tb_i2c_target.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_if.sv
// Bus-side and register-port signals of the I2C target.
// The master modport is the view from the pads/register file.
interface i2c_target_if;
    logic       scl;
    logic       sda;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       busy;

    modport slave (
        input  scl, sda, rd_data,
        output sda_oe, reg_addr, wr_data, wr_en, rd_req, busy
    );

    modport master (
        output scl, sda, rd_data,
        input  sda_oe, reg_addr, wr_data, wr_en, rd_req, busy
    );
endinterface

// File: rtl/i2c_target.sv
// 7-bit-address I2C target with auto-incrementing register pointer.
// SCL/SDA are synchronised and stability-filtered before edge detection.
module i2c_target #(
    parameter int unsigned FILT_LEN = 3,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [6:0]   i_dev_addr,
    i2c_target_if.slave  bus
);
    localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, MACK, WAIT_STOP
    } state_t;

    // index 0 = SCL, index 1 = SDA
    logic [1:0]       sync1, sync2, filt, filt_d;
    logic [CNT_W-1:0] flt_cnt [2];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1  <= '1;
            sync2  <= '1;
            filt   <= '1;
            filt_d <= '1;
            for (int unsigned i = 0; i < 2; i++) flt_cnt[i] <= '0;
        end else begin
            sync1  <= {bus.sda, bus.scl};
            sync2  <= sync1;
            filt_d <= filt;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == CNT_W'(FILT_LEN - 1)) begin
                    filt[i]    <= sync2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
    assign scl_f     = filt[0];
    assign sda_f     = filt[1];
    assign scl_rise  =  scl_f & ~filt_d[0];
    assign scl_fall  = ~scl_f &  filt_d[0];
    assign start_det =  scl_f &  filt_d[0] &  filt_d[1] & ~sda_f;
    assign stop_det  =  scl_f &  filt_d[0] & ~filt_d[1] &  sda_f;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] rx_byte;
    logic       rw, ack_on, rd_pend, rd_load;
    logic [1:0] rd_pipe;

    assign rx_byte = {shreg[6:0], sda_f};
    assign rd_load = (RD_LAT == 2) ? rd_pipe[1] : rd_pipe[0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            bit_cnt      <= 3'd7;
            shreg        <= '0;
            rw           <= 1'b0;
            ack_on       <= 1'b0;
            rd_pend      <= 1'b0;
            rd_pipe      <= '0;
            bus.sda_oe   <= 1'b0;
            bus.reg_addr <= '0;
            bus.wr_data  <= '0;
            bus.wr_en    <= 1'b0;
            bus.rd_req   <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            bus.wr_en  <= 1'b0;
            bus.rd_req <= rd_pend;
            rd_pend    <= 1'b0;
            rd_pipe    <= {rd_pipe[0], bus.rd_req};
            if (bus.wr_en) bus.reg_addr <= bus.reg_addr + 8'd1;
            if (rd_load)   shreg        <= bus.rd_data;

            if (start_det) begin
                state      <= ADDR;
                bit_cnt    <= 3'd7;
                bus.sda_oe <= 1'b0;
                ack_on     <= 1'b0;
                rd_pend    <= 1'b0;
                rd_pipe    <= '0;
            end else if (stop_det) begin
                state      <= IDLE;
                bus.sda_oe <= 1'b0;
                bus.busy   <= 1'b0;
                ack_on     <= 1'b0;
                rd_pend    <= 1'b0;
                rd_pipe    <= '0;
            end else begin
                case (state)
                    IDLE: bus.busy <= 1'b0;
                    ADDR, PTR, WDATA: if (scl_rise) begin
                        shreg <= rx_byte;
                        if (bit_cnt != 3'd0) begin
                            bit_cnt <= bit_cnt - 3'd1;
                        end else if (state == PTR) begin
                            bus.reg_addr <= rx_byte;
                            state        <= PTR_ACK;
                        end else if (state == WDATA) begin
                            bus.wr_data <= rx_byte;
                            bus.wr_en   <= 1'b1;
                            state       <= WDATA_ACK;
                        end else if (shreg[6:0] == i_dev_addr) begin
                            rw      <= sda_f;
                            rd_pend <= sda_f;
                            state   <= ADDR_ACK;
                        end else begin
                            state <= WAIT_STOP;
                        end
                    end
                    // First fall drives the ACK, second fall ends the ACK clock.
                    ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!ack_on) begin
                            ack_on     <= 1'b1;
                            bus.sda_oe <= 1'b1;
                            bus.busy   <= 1'b1;
                        end else begin
                            ack_on  <= 1'b0;
                            bit_cnt <= 3'd7;
                            if (state == ADDR_ACK && rw) begin
                                bus.sda_oe <= ~shreg[7];
                                state      <= RDATA;
                            end else begin
                                bus.sda_oe <= 1'b0;
                                state      <= (state == ADDR_ACK) ? PTR : WDATA;
                            end
                        end
                    end
                    RDATA: if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            bus.sda_oe <= 1'b0;
                            ack_on     <= 1'b0;
                            state      <= MACK;
                        end else begin
                            shreg      <= {shreg[6:0], 1'b0};
                            bus.sda_oe <= ~shreg[6];
                            bit_cnt    <= bit_cnt - 3'd1;
                        end
                    end
                    // ack_on here marks a master ACK already seen, awaiting the fall.
                    MACK: begin
                        if (scl_rise && !ack_on) begin
                            if (!sda_f) begin
                                ack_on       <= 1'b1;
                                bus.reg_addr <= bus.reg_addr + 8'd1;
                                rd_pend      <= 1'b1;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end else if (scl_fall && ack_on) begin
                            ack_on     <= 1'b0;
                            bit_cnt    <= 3'd7;
                            bus.sda_oe <= ~shreg[7];
                            state      <= RDATA;
                        end
                    end
                    WAIT_STOP: bus.sda_oe <= 1'b0;
                    default:   state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged I2C master plus a read-data model.
`timescale 1ns/1ps
module tb_i2c_target;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] dev_addr = 7'h48;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    int         total = 0;
    int         bad   = 0;

    i2c_target_if bus();
    assign bus.scl = m_scl;
    assign bus.sda = m_sda & ~bus.sda_oe;

    i2c_target #(.FILT_LEN(3), .RD_LAT(1)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_dev_addr (dev_addr),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // register file read model: data = address ^ 0xFF, one cycle latency
    initial bus.rd_data = 8'h00;
    always @(posedge clk) if (bus.rd_req) bus.rd_data <= bus.reg_addr ^ 8'hFF;

    logic [7:0] wa [16];
    logic [7:0] wd [16];
    logic [7:0] ra [16];
    int         wn = 0, rn = 0, both_cnt = 0;
    logic       oe_any = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_en) begin
                if (wn < 16) begin wa[wn] = bus.reg_addr; wd[wn] = bus.wr_data; end
                wn++;
            end
            if (bus.rd_req) begin
                if (rn < 16) ra[rn] = bus.reg_addr;
                rn++;
            end
            if (bus.wr_en && bus.rd_req) both_cnt++;
            if (bus.sda_oe) oe_any = 1'b1;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: run did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // enters with SCL low, leaves with SCL low
    task automatic bit_out(input logic b, output logic seen);
        m_sda = b;    wait_cyc(6);
        m_scl = 1'b1; wait_cyc(6);
        seen = bus.sda;
        wait_cyc(6);
        m_scl = 1'b0; wait_cyc(6);
    endtask

    task automatic i2c_start;
        m_sda = 1'b1; wait_cyc(6);
        m_scl = 1'b1; wait_cyc(12);
        m_sda = 1'b0; wait_cyc(12);
        m_scl = 1'b0; wait_cyc(6);
    endtask

    task automatic i2c_stop;
        m_sda = 1'b0; wait_cyc(6);
        m_scl = 1'b1; wait_cyc(12);
        m_sda = 1'b1; wait_cyc(12);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_out(b[i], s);
        bit_out(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_out(1'b1, s);
            d = {d[6:0], s};
        end
        bit_out(mack, s);
    endtask

    logic       ack, s;
    logic [7:0] d;

    initial begin
        wait_cyc(4);
        check("rst_sda_oe",   32'(bus.sda_oe),   32'h0);
        check("rst_wr_en",    32'(bus.wr_en),    32'h0);
        check("rst_rd_req",   32'(bus.rd_req),   32'h0);
        check("rst_wr_data",  32'(bus.wr_data),  32'h0);
        check("rst_reg_addr", 32'(bus.reg_addr), 32'h0);
        check("rst_busy",     32'(bus.busy),     32'h0);
        rst = 1'b0;
        wait_cyc(12);

        // write burst
        wn = 0;
        i2c_start;
        send_byte(8'h90, ack); check("wb_addr_ack", 32'(ack), 32'h0);
        check("wb_busy", 32'(bus.busy), 32'h1);
        send_byte(8'h10, ack); check("wb_ptr_ack", 32'(ack), 32'h0);
        send_byte(8'hA5, ack); check("wb_d0_ack", 32'(ack), 32'h0);
        send_byte(8'h5A, ack); check("wb_d1_ack", 32'(ack), 32'h0);
        i2c_stop;
        check("wb_count", 32'(wn), 32'd2);
        check("wb_a0", 32'(wa[0]), 32'h10); check("wb_d0", 32'(wd[0]), 32'hA5);
        check("wb_a1", 32'(wa[1]), 32'h11); check("wb_d1", 32'(wd[1]), 32'h5A);
        check("wb_ptr_end", 32'(bus.reg_addr), 32'h12);
        check("wb_busy_end", 32'(bus.busy), 32'h0);

        // combined read
        rn = 0;
        i2c_start;
        send_byte(8'h90, ack); check("rd_waddr_ack", 32'(ack), 32'h0);
        send_byte(8'h20, ack); check("rd_ptr_ack", 32'(ack), 32'h0);
        i2c_start;
        send_byte(8'h91, ack); check("rd_raddr_ack", 32'(ack), 32'h0);
        read_byte(1'b0, d); check("rd_b0", 32'(d), 32'hDF);
        read_byte(1'b0, d); check("rd_b1", 32'(d), 32'hDE);
        read_byte(1'b1, d); check("rd_b2", 32'(d), 32'hDD);
        check("rd_release", 32'(bus.sda_oe), 32'h0);
        i2c_stop;
        check("rd_req_count", 32'(rn), 32'd3);
        check("rd_req0", 32'(ra[0]), 32'h20);
        check("rd_req1", 32'(ra[1]), 32'h21);
        check("rd_req2", 32'(ra[2]), 32'h22);
        check("rd_ptr_end", 32'(bus.reg_addr), 32'h22);

        // address mismatch
        wn = 0; oe_any = 1'b0;
        i2c_start;
        send_byte(8'h92, ack); check("mm_noack", 32'(ack), 32'h1);
        send_byte(8'h55, ack);
        i2c_stop;
        check("mm_no_wr", 32'(wn), 32'd0);
        check("mm_no_oe", 32'(oe_any), 32'h0);

        // pointer wrap
        wn = 0;
        i2c_start;
        send_byte(8'h90, ack);
        send_byte(8'hFF, ack); check("wr_ptr_ack", 32'(ack), 32'h0);
        send_byte(8'h11, ack);
        send_byte(8'h22, ack); check("wr_d1_ack", 32'(ack), 32'h0);
        i2c_stop;
        check("wr_count", 32'(wn), 32'd2);
        check("wr_a0", 32'(wa[0]), 32'hFF); check("wr_d0", 32'(wd[0]), 32'h11);
        check("wr_a1", 32'(wa[1]), 32'h00); check("wr_d1", 32'(wd[1]), 32'h22);
        check("wr_ptr_end", 32'(bus.reg_addr), 32'h01);

        // abort: STOP after 4 data bits
        wn = 0;
        i2c_start;
        send_byte(8'h90, ack);
        send_byte(8'h30, ack);
        for (int i = 0; i < 4; i++) bit_out(1'b1, s);
        i2c_stop;
        check("ab_no_wr", 32'(wn), 32'd0);
        check("ab_ptr", 32'(bus.reg_addr), 32'h30);

        // 2-cycle SDA glitch while SCL high must not look like START
        oe_any = 1'b0;
        m_sda = 1'b0; wait_cyc(2);
        m_sda = 1'b1; wait_cyc(12);
        m_scl = 1'b0; wait_cyc(6);
        send_byte(8'h90, ack); check("gl_noack", 32'(ack), 32'h1);
        check("gl_no_oe", 32'(oe_any), 32'h0);
        i2c_stop;

        // reset while driving a 0 data bit (pointer 0x80 -> data 0x7F)
        i2c_start;
        send_byte(8'h90, ack);
        send_byte(8'h80, ack);
        i2c_start;
        send_byte(8'h91, ack);
        wait_cyc(2);
        check("rr_driving0", 32'(bus.sda_oe), 32'h1);
        rst = 1'b1; wait_cyc(1);
        check("rr_oe_released", 32'(bus.sda_oe), 32'h0);
        check("rr_ptr_cleared", 32'(bus.reg_addr), 32'h0);
        check("rr_busy_cleared", 32'(bus.busy), 32'h0);
        rst = 1'b0; wait_cyc(12);
        i2c_start;
        send_byte(8'h90, ack); check("rr_restart_ack", 32'(ack), 32'h0);
        send_byte(8'h33, ack);
        i2c_stop;
        check("rr_restart_ptr", 32'(bus.reg_addr), 32'h33);

        check("no_wr_rd_overlap", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
